// File: rtl/jk_excitation_driver.sv
// Converts a frame of target Q bits into registered JK excitation for an attached
// flop, then checks the flop feedback against each target bit and reports per frame.
module jk_excitation_driver #(
  parameter int WIDTH = 16,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [WIDTH-1:0] pat_bits,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             toggle_pref,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             done,
  output logic             mismatch,
  output logic [LEN_W-1:0] err_cnt,
  output logic [LEN_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_TWO  = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bits_q, bits_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             tog_q, tog_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             j_q, j_d, k_q, k_d, done_q, done_d;
  logic             mismatch_q, mismatch_d;
  logic [LEN_W-1:0] err_cnt_q, err_cnt_d, first_q, first_d;

  logic             accept_s;
  logic [LEN_W-1:0] len_clamp_s;
  logic             cmp_en_s;
  logic             cmp_fail_s;
  logic [LEN_W-1:0] cmp_idx_s;
  logic [1:0]       jk_s;

  // {j,k} that moves present state p to target t, resolving don't-cares by preference
  function automatic logic [1:0] excite(input logic p, input logic t, input logic tog);
    logic [1:0] jk;
    case ({tog, p, t})
      3'b000:  jk = 2'b00;
      3'b001:  jk = 2'b10;
      3'b010:  jk = 2'b01;
      3'b011:  jk = 2'b00;
      3'b100:  jk = 2'b01;
      3'b101:  jk = 2'b11;
      3'b110:  jk = 2'b11;
      3'b111:  jk = 2'b10;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

  function automatic logic bit_at(input logic [WIDTH-1:0] v, input logic [LEN_W-1:0] i);
    logic [WIDTH-1:0] sh;
    sh = v >> i;
    return sh[0];
  endfunction

  assign pat_ready   = (state_q == S_IDLE) && reset_n;
  assign accept_s    = pat_valid && pat_ready;
  assign len_clamp_s = (pat_len > LEN_MAX) ? LEN_MAX : pat_len;

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = (len_clamp_s == LEN_ZERO) ? S_DRAIN : S_DRIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (idx_q >= len_q) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_DRIVE;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // excitation and compare: bit i is checked two edges after it is issued
  always_comb begin
    bits_d     = bits_q;
    len_d      = len_q;
    tog_d      = tog_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    mismatch_d = mismatch_q;
    err_cnt_d  = err_cnt_q;
    first_d    = first_q;
    cmp_en_s   = 1'b0;
    cmp_idx_s  = LEN_ZERO;
    jk_s       = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          bits_d     = pat_bits;
          len_d      = len_clamp_s;
          tog_d      = toggle_pref;
          idx_d      = LEN_ONE;
          mismatch_d = 1'b0;
          err_cnt_d  = LEN_ZERO;
          first_d    = LEN_ZERO;
          if (len_clamp_s != LEN_ZERO) begin
            jk_s = excite(q_fb, pat_bits[0], toggle_pref);
          end else begin
            jk_s = 2'b00;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_DRIVE: begin
        if (idx_q < len_q) begin
          jk_s  = excite(bit_at(bits_q, idx_q - LEN_ONE), bit_at(bits_q, idx_q), tog_q);
          idx_d = idx_q + LEN_ONE;
        end else begin
          jk_s = 2'b00;
        end
        if (idx_q >= LEN_TWO) begin
          cmp_en_s  = 1'b1;
          cmp_idx_s = idx_q - LEN_TWO;
        end else begin
          cmp_en_s = 1'b0;
        end
      end
      S_DRAIN: begin
        done_d = 1'b1;
        if (len_q != LEN_ZERO) begin
          cmp_en_s  = 1'b1;
          cmp_idx_s = len_q - LEN_ONE;
        end else begin
          cmp_en_s = 1'b0;
        end
      end
      default: begin
        jk_s = 2'b00;
      end
    endcase
    {j_d, k_d} = jk_s;
    cmp_fail_s = cmp_en_s && (q_fb != bit_at(bits_q, cmp_idx_s));
    err_cnt_d  = cmp_fail_s ? (err_cnt_q + LEN_ONE) : err_cnt_d;
    first_d    = (cmp_fail_s && !mismatch_q) ? cmp_idx_s : first_d;
    mismatch_d = cmp_fail_s ? 1'b1 : mismatch_d;
  end

  // datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bits_q     <= {WIDTH{1'b0}};
      len_q      <= LEN_ZERO;
      tog_q      <= 1'b0;
      idx_q      <= LEN_ZERO;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= LEN_ZERO;
      first_q    <= LEN_ZERO;
    end else begin
      bits_q     <= bits_d;
      len_q      <= len_d;
      tog_q      <= tog_d;
      idx_q      <= idx_d;
      j_q        <= j_d;
      k_q        <= k_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
      first_q    <= first_d;
    end
  end

  assign j             = j_q;
  assign k             = k_q;
  assign done          = done_q;
  assign mismatch      = mismatch_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: frames are scored against a JK-semantics model;
// a behavioural JK flop (or a stuck-at fault) closes the feedback loop.
module tb_jk_excitation_driver;
  localparam int W     = 16;
  localparam int LW    = $clog2(W + 1);
  localparam int FM_OK = 0;
  localparam int FM_S0 = 1;
  localparam int FM_S1 = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pat_valid;
  logic          pat_ready;
  logic [W-1:0]  pat_bits;
  logic [LW-1:0] pat_len;
  logic          toggle_pref;
  logic          j, k;
  logic          q_fb;
  logic          done, mismatch;
  logic [LW-1:0] err_cnt, first_err_idx;

  logic q_flop = 1'b0;
  int   fmode  = FM_OK;
  bit   mon_on = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  typedef struct {
    int           len;
    logic [2*W-1:0] jk;
    int           err;
    int           first;
    bit           mm;
  } exp_t;
  exp_t exp_q[$];

  jk_excitation_driver #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pat_valid     (pat_valid),
    .pat_ready     (pat_ready),
    .pat_bits      (pat_bits),
    .pat_len       (pat_len),
    .toggle_pref   (toggle_pref),
    .j             (j),
    .k             (k),
    .q_fb          (q_fb),
    .done          (done),
    .mismatch      (mismatch),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx)
  );

  always #5 clk = ~clk;

  // behavioural JK flop driven by the DUT
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   q_flop <= 1'b0;
      2'b10:   q_flop <= 1'b1;
      2'b11:   q_flop <= ~q_flop;
      default: q_flop <= q_flop;
    endcase
  end

  assign q_fb = (fmode == FM_OK) ? q_flop : (fmode == FM_S1);

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Among the JK codes whose characteristic equation reaches t from p, pick the one
  // with the fewest ones (hold-preferred) or the most ones (toggle-preferred).
  function automatic logic [1:0] pick(input bit p, input bit t, input bit tog);
    logic [1:0] code, best_code;
    int best, ones;
    bit nx;
    best = -1;
    best_code = 2'b00;
    for (int c = 0; c < 4; c++) begin
      code = 2'(c);
      if (code == 2'b11) nx = !p;
      else if (code == 2'b10) nx = 1'b1;
      else if (code == 2'b01) nx = 1'b0;
      else nx = p;
      ones = int'(code[1]) + int'(code[0]);
      if (nx == t && (best < 0 || (tog ? (ones > best) : (ones < best)))) begin
        best = ones;
        best_code = code;
      end
    end
    return best_code;
  endfunction

  task automatic wait_ready();
    int guard = 0;
    while (!pat_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!pat_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: pat_ready=%0d after %0d cycles, required 1", pat_ready, guard);
    end
  endtask

  task automatic send(input logic [W-1:0] bits, input int len, input bit tog,
                      input int fm, input int hold);
    exp_t e;
    bit prev, t, stuck;
    int n, hl;
    wait_ready();
    fmode = fm;
    stuck = (fm == FM_S1);
    prev  = (fm == FM_OK) ? q_flop : stuck;
    n     = (len > W) ? W : len;
    e.len = n; e.jk = '0; e.err = 0; e.first = 0; e.mm = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = bits[i];
      e.jk[2*i +: 2] = pick(prev, t, tog);
      prev = t;
      if (fm != FM_OK && t != stuck) begin
        if (e.err == 0) e.first = i;
        e.err++;
      end
    end
    e.mm = (e.err > 0);
    exp_q.push_back(e);
    pat_bits = bits; pat_len = LW'(len); toggle_pref = tog; pat_valid = 1'b1;
    @(posedge clk); #1;
    hl = (hold > n) ? n : hold;
    for (int h = 0; h < hl; h++) begin
      pat_bits = W'($urandom); pat_len = LW'($urandom); toggle_pref = 1'($urandom);
      @(posedge clk); #1;
    end
    pat_valid = 1'b0;
  endtask

  // monitor: pops the expected frame at acceptance and checks every following cycle
  initial begin : monitor
    exp_t e;
    int   c;
    bit   rst_seen;
    c = -1;
    rst_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (c >= 0) begin
          if (rst_seen) begin
            check("abort_jk", int'({j, k}), 0);
            check("abort_done", done, 0);
            c = -1;
          end else begin
            if (c < e.len) check($sformatf("jk_bit%0d", c), int'({j, k}), int'(e.jk[2*c +: 2]));
            else check("jk_after_frame", int'({j, k}), 0);
            if (c == e.len + 1) begin
              check("done", done, 1);
              check("ready_with_done", pat_ready, 1);
              check("mismatch", mismatch, int'(e.mm));
              check("err_cnt", err_cnt, e.err);
              if (e.mm) check("first_err_idx", first_err_idx, e.first);
              c = -1;
            end else begin
              check("done_early", done, 0);
              check("ready_busy", pat_ready, 0);
              c++;
            end
          end
        end else begin
          check("idle_done", done, 0);
        end
        if (c < 0 && pat_valid && pat_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: acceptance with no expected frame queued");
          end else begin
            e = exp_q.pop_front();
            c = 0;
          end
        end
        rst_seen = !reset_n;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset_n = 1'b0; pat_valid = 1'b0; pat_bits = '0; pat_len = '0; toggle_pref = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", pat_ready, 1);
    check("rst_jk", int'({j, k}), 0);
    check("rst_done", done, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_err_cnt", err_cnt, 0);
    mon_on = 1'b1;
    @(posedge clk); #1;

    send(16'h0006, 4, 1'b0, FM_OK, 0);
    send(16'h0006, 4, 1'b1, FM_OK, 2);
    send(16'h0005, 4, 1'b0, FM_S0, 1);
    send(16'h0000, 1, 1'b0, FM_OK, 0);
    send(16'h0005, 4, 1'b0, FM_S0, 0);

    // reset mid-idle with non-zero status
    wait_ready();
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    check("ready_in_reset", pat_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("idle_rst_jk", int'({j, k}), 0);
    check("idle_rst_mismatch", mismatch, 0);
    check("idle_rst_err_cnt", err_cnt, 0);
    check("idle_rst_first", first_err_idx, 0);
    check("idle_rst_ready", pat_ready, 1);
    @(posedge clk); #1;

    send(16'h1234, 0, 1'b0, FM_OK, 0);
    send(16'h1234, 0, 1'b1, FM_S1, 0);
    send(16'hBEEF, 20, 1'b1, FM_OK, 3);
    send(16'h00FF, 16, 1'b0, FM_S1, 0);

    // reset sampled at edge A+3 of a 16-bit frame
    send(16'hA5C3, 16, 1'b0, FM_OK, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    send(16'h0002, 2, 1'b0, FM_OK, 0);

    for (int f = 0; f < 60; f++) begin
      int r, len, fm;
      r   = $urandom_range(0, 9);
      fm  = (r < 6) ? FM_OK : ((r < 8) ? FM_S0 : FM_S1);
      len = $urandom_range(0, 20);
      send(W'($urandom), len, 1'($urandom), fm, $urandom_range(0, 3));
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
      end
    end

    wait_ready();
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Stimulus-side companion to the team's JK flip-flop. It accepts a frame of target Q values through a valid/ready handshake and converts each bit into the JK excitation `j`/`k` that moves the flop's present state to that target. It also monitors the flop's `q` through `q_fb` and reports per-frame mismatches. It sits between test/sequencing logic and any `jk_if`-attached JK flop, so a bench or controller commands states rather than raw J/K codes.

## Interface
- `WIDTH`, 16, maximum frame length in bits.
- `LEN_W`, `$clog2(WIDTH+1)`, width of length, count and index fields.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `pat_valid`  in  1  frame offered.
- `pat_ready`  out  1  driver idle and able to accept a frame.
- `pat_bits`  in  WIDTH  target Q sequence, LSB first.
- `pat_len`  in  LEN_W  number of bits to drive (0..WIDTH); values above WIDTH are clamped to WIDTH.
- `toggle_pref`  in  1  don't-care resolution: 0 = hold-preferred, 1 = toggle-preferred.
- `j`, `k`  out  1 each  registered excitation to the flop.
- `q_fb`  in  1  flop output feedback.
- `done`  out  1  one-cycle pulse at end of frame.
- `mismatch`  out  1  at least one compare failed this frame.
- `err_cnt`  out  LEN_W  number of failed compares this frame.
- `first_err_idx`  out  LEN_W  bit index of the first failure; meaningful only when `mismatch`=1.

## Operation
- FSM states:
  - IDLE: `pat_ready`=1. On `pat_valid`, go to DRIVE, or to DRAIN if len=0.
  - DRIVE: run until all bits are issued, then go to DRAIN.
  - DRAIN: perform the last compare, then return to IDLE with `done`.
- `pat_ready` = (state==IDLE) && `reset_n`.
- Acceptance edge A (`pat_valid && pat_ready`) latches:
  - the pattern, clamped length, and `toggle_pref`;
  - the model state `q_m <= q_fb`;
  - clears `mismatch`, `err_cnt` and `first_err_idx`.
- Excitation for present state p and target t:
  - hold-preferred: 0→0 = 00, 0→1 = 10, 1→0 = 01, 1→1 = 00.
  - toggle-preferred: 0→0 = 01, 0→1 = 11, 1→0 = 11, 1→1 = 10.
- Present state p is `q_m` for bit 0 and target bit i-1 for bit i. `q_fb` never feeds excitation after acceptance.
- Compare: each driven bit i is checked against `q_fb` exactly once. On a failure:
  - `err_cnt` increments (it cannot overflow, since the count is at most WIDTH);
  - on the first failure only, `first_err_idx` <= i;
  - `mismatch` <= 1.
- The status outputs hold their values until the next acceptance.
- Reset (`reset_n`=0 at an edge):
  - state <= IDLE;
  - `j`, `k`, `done`, `mismatch`, `err_cnt`, `first_err_idx` all <= 0;
  - a frame in flight is aborted with no `done`.

## Timing
- Edge A: `j`/`k` <= excite(`q_fb`, bit0).
- Edge A+i, for 1 ≤ i < len: `j`/`k` <= excite(bit i-1, bit i).
- Edge A+len: `j`/`k` <= 00, and they stay 00 until the next acceptance.
- The flop captures bit i at edge A+i+1. The driver compares `q_fb` to bit i at edge A+i+2.
- `done` is registered high at edge A+len+1 and lasts exactly one cycle. For len=0 this is edge A+1.
- `pat_ready` rises in the same cycle as `done`. The earliest next acceptance is edge A+len+2, when `q_fb` is stable.
- No back-to-back overlap of frames. Throughput is len+2 cycles per frame.
- `pat_valid` held while not ready has no effect. `pat_bits`, `pat_len` and `toggle_pref` are don't-care outside the acceptance edge.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles mid-idle → `j`=`k`=0, `done`=0, `mismatch`=0, `err_cnt`=0. `pat_ready`=0 during reset and 1 after release.
- Hold-preferred frame, real JK flop attached, q=0:
  - stimulus: `pat_bits`=0x0006, len=4, `toggle_pref`=0;
  - `j`/`k` = 00, 10, 00, 01 after edges A..A+3, then 00;
  - `q` = 0, 1, 1, 0;
  - `done` at A+5, `mismatch`=0, `err_cnt`=0.
- Toggle-preferred, same frame: `j`/`k` = 01, 11, 10, 11. Same `q` sequence, `mismatch`=0.
- Fault injection:
  - stimulus: `q_fb` tied 0, `pat_bits`=0x0005, len=4, `toggle_pref`=0;
  - `j`/`k` = 10, 01, 10, 01;
  - result: `mismatch`=1, `err_cnt`=2, `first_err_idx`=0;
  - a following frame with len=1 and bits=0 clears the status to 0/0.
- Length boundaries:
  - len=0: `done` at A+1, `j`/`k` stay 00, status 0;
  - len=20 clamps to 16: 16 bits driven, `done` at A+17.
- Reset mid-frame: 16-bit frame, `reset_n`=0 at edge A+3 → `j`=`k`=0 the next cycle, no `done`. After release, a new len=2 frame completes normally at A'+3.
